load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Initiator side of the 16-bit data-memory port. Sits between the CPU execute/memory stage and the word-organised data memory.
- Accepts byte-addressed load/store requests from the pipeline through a valid/ready handshake, converts them into word accesses, and returns one response pulse per request.
- Byte stores are done as read-modify-write, because the memory is word-only.
- The data memory reads combinationally from its address and writes on the falling clock edge. This block drives all memory-side outputs from registers updated on the rising edge.

Parameters:
- MEM, 64, memory depth in 16-bit words; used only by the optional range check.

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous active-high reset
- req_valid  input  1  pipeline presents a request
- req_ready  output  1  block can accept a request; high only in IDLE
- req_write  input  1  1 = store, 0 = load
- req_size  input  1  0 = byte, 1 = halfword (16-bit)
- req_signed  input  1  byte loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  input  16  byte address
- req_wdata  input  16  store data; byte stores use bits [7:0]
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  16  load result; 0 for stores and errors
- resp_err  output  1  request faulted; valid with resp_valid
- mem_address  output  16  word address to data memory, equal to req_addr >> 1
- mem_wd  output  16  write data to data memory
- mem_we  output  1  write enable to data memory
- mem_rd  input  16  combinational read data from data memory

Behaviour:
- States: IDLE, READ, RMW_READ, WRITE, RESP.
- Reset (async, immediate): state = IDLE, mem_we = 0, mem_address = 0, mem_wd = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0. req_ready = 1 while in reset.
- req_ready = (state == IDLE). It is decoded from state only, never from req_valid.
- Acceptance: at a posedge with req_valid && req_ready:
  - latch all request fields;
  - mem_address <= {1'b0, req_addr[15:1]};
  - lane = req_addr[0] (0 → bits [7:0], 1 → bits [15:8]; little-endian).
- Misaligned halfword (req_size = 1 and req_addr[0] = 1):
  - IDLE → RESP with resp_err = 1 and resp_rdata = 0;
  - mem_we never asserted.
- Halfword load: IDLE → READ. At the end of READ, resp_rdata <= mem_rd. READ → RESP.
- Byte load: IDLE → READ. At the end of READ, take the selected lane of mem_rd and sign- or zero-extend it per req_signed. READ → RESP.
- Halfword store:
  - IDLE → WRITE with mem_wd = req_wdata and mem_we = 1 for exactly one cycle; the memory commits on the negedge inside WRITE.
  - WRITE → RESP.
- Byte store:
  - IDLE → RMW_READ. At the end of RMW_READ, capture mem_rd and merge req_wdata[7:0] into the selected lane; the other lane is preserved.
  - RMW_READ → WRITE (merged word, mem_we = 1) → RESP.
- RESP: resp_valid = 1 for exactly one cycle, then → IDLE. There is no response backpressure.
- resp_rdata and resp_err hold their last values until the next RESP. resp_valid = 0 outside RESP.
- mem_we = 1 only in the WRITE state.
- mem_address is stable from acceptance until the return to IDLE.
- Latency (acceptance edge to resp_valid high):
  - halfword load, byte load, halfword store: 2 cycles;
  - byte store: 3 cycles;
  - misaligned: 1 cycle.
- req_valid while busy is ignored; the requester holds the request until it sees ready.
- Reset asserted mid-operation, including during WRITE before the negedge:
  - mem_we drops immediately and no memory write occurs;
  - any pending response is discarded.
- Address wrap: none. Bit 15 of mem_address is always 0.

Optional Feature:
- Macro: LSU_RANGE_CHECK_EN.
- Defined:
  - at acceptance, if (req_addr >> 1) >= MEM, go IDLE → RESP with resp_err = 1 and resp_rdata = 0;
  - no READ or WRITE state is entered and mem_we stays 0;
  - the range check and the misalignment check both set resp_err.
- Not defined:
  - no range check; the word address is forwarded unchanged;
  - the only error source is misalignment.

Test Plan:
- Halfword store addr 0x0004, wdata 0xBEEF → mem_address 0x0002, mem_we high for exactly 1 cycle, resp_valid 2 cycles after acceptance, resp_err 0. Then halfword load 0x0004 → resp_rdata 0xBEEF.
- Memory word 2 = 0x1234; byte store addr 0x0005, wdata 0x00AB → RMW sequence, word 2 becomes 0xAB34, resp_valid 3 cycles after acceptance.
- Word 3 = 0x80F0; byte load addr 0x0006: signed → 0xFFF0, unsigned → 0x00F0. Byte load addr 0x0007, signed → 0xFF80.
- Halfword load addr 0x0003 → resp_err 1, resp_rdata 0x0000, resp_valid 1 cycle after acceptance, mem_we never high.
- Reset raised during the WRITE cycle of a store to addr 0x0008 (word 4 = 0x5555, wdata 0x1111) → mem_we falls immediately, word 4 still 0x5555, no resp_valid, req_ready 1.
- With LSU_RANGE_CHECK_EN and MEM = 64, halfword store addr 0x0080 → resp_err 1, mem_we stays 0. Without the macro, the same request writes word 0x0040.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the 16-bit word-organised data-memory port.
// Turns byte-addressed load/store requests from the pipeline into word accesses.
// A request is accepted through a valid/ready handshake and gets one response pulse.
// Byte stores use read-modify-write, because the memory only writes whole words.
// The memory reads combinationally and writes on the falling edge.
// Every memory-side output therefore comes from a register updated on the rising edge.
// Optional build macro: LSU_RANGE_CHECK_EN. When defined, any access whose word
// address is at or beyond MEM is faulted without touching memory.
module load_store_unit #(
  parameter int MEM = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_size,
  input  logic        req_signed,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wd,
  output logic        mem_we,
  input  logic [15:0] mem_rd
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] READ     = 3'd1;
  localparam logic [2:0] RMW_READ = 3'd2;
  localparam logic [2:0] WRITE    = 3'd3;
  localparam logic [2:0] RESP     = 3'd4;

  logic [2:0]  state;

  // Request fields still needed after acceptance.
  logic        lat_size;
  logic        lat_signed;
  logic        lat_lane;
  logic [7:0]  lat_wbyte;

  logic [7:0]  rd_byte;
  logic [15:0] load_data;
  logic [15:0] merged_word;
  logic        misaligned;
  logic        out_of_range;
  logic        req_fault;

  // Ready is decoded from state only, so it is independent of req_valid.
  assign req_ready = (state == IDLE);

`ifdef LSU_RANGE_CHECK_EN
  localparam logic [16:0] MEM_LIMIT = 17'(MEM);
  assign out_of_range = ({2'b00, req_addr[15:1]} >= MEM_LIMIT);
`else
  // Without the range check the depth has no effect. It is still referenced here
  // so the parameter is not left dangling.
  logic unused_mem_depth;
  assign unused_mem_depth = (MEM > 0);
  assign out_of_range     = 1'b0;
`endif

  // Decode the accepted request's fault and build the load and merge words.
  always_comb begin
    // NOTE: every output of this block gets a value on every path, so no latch is inferred.
    misaligned  = req_size & req_addr[0];
    req_fault   = misaligned | out_of_range;
    rd_byte     = lat_lane ? mem_rd[15:8] : mem_rd[7:0];
    load_data   = mem_rd;
    if (!lat_size) begin
      load_data = lat_signed ? {{8{rd_byte[7]}}, rd_byte} : {8'h00, rd_byte};
    end
    merged_word = lat_lane ? {lat_wbyte, mem_rd[7:0]} : {mem_rd[15:8], lat_wbyte};
  end

  // Sequencer. It also registers every memory-side and response output.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is assigned non-blocking, so all registers update together at the edge.
    if (reset) begin
      state       <= IDLE;
      mem_we      <= 1'b0;
      mem_address <= 16'h0000;
      mem_wd      <= 16'h0000;
      resp_valid  <= 1'b0;
      resp_rdata  <= 16'h0000;
      resp_err    <= 1'b0;
      lat_size    <= 1'b0;
      lat_signed  <= 1'b0;
      lat_lane    <= 1'b0;
      lat_wbyte   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_size    <= req_size;
            lat_signed  <= req_signed;
            lat_lane    <= req_addr[0];
            lat_wbyte   <= req_wdata[7:0];
            mem_address <= {1'b0, req_addr[15:1]};
            if (req_fault) begin
              resp_err   <= 1'b1;
              resp_rdata <= 16'h0000;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else if (req_write && req_size) begin
              mem_wd <= req_wdata;
              mem_we <= 1'b1;
              state  <= WRITE;
            end else if (req_write) begin
              state <= RMW_READ;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          resp_rdata <= load_data;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RMW_READ: begin
          mem_wd <= merged_word;
          mem_we <= 1'b1;
          state  <= WRITE;
        end
        WRITE: begin
          mem_we     <= 1'b0;
          resp_rdata <= 16'h0000;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          mem_we     <= 1'b0;
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
